input_route_ctrl: RTL and testbench

INPUT_ROUTE_CTRL -- requirements
Module: input_route_ctrl

---
 rtl/noc_pkg.sv | 39 +++
 rtl/route_calc.sv | 35 +++
 rtl/input_route_ctrl.sv | 120 ++++++++++++
 tb/tb_input_route_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg -- shared definitions for the NoC input route controller.
//   Port codes (3-bit), flit-type codes (2-bit), controller state type
//   and a small flit-classification helper.
package noc_pkg;

    // Output port codes
    localparam logic [2:0] PORT_LOCAL = 3'b000;
    localparam logic [2:0] PORT_E     = 3'b001;
    localparam logic [2:0] PORT_W     = 3'b010;
    localparam logic [2:0] PORT_N     = 3'b011;
    localparam logic [2:0] PORT_S     = 3'b100;
    localparam logic [2:0] PORT_NONE  = 3'b111;

    // Flit type field (top two bits of a flit)
    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b01;
    localparam logic [1:0] FLIT_HEAD   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    // Controller state
    typedef logic [1:0] irc_state_t;
    localparam irc_state_t ST_IDLE = 2'd0;
    localparam irc_state_t ST_REQ  = 2'd1;
    localparam irc_state_t ST_XFER = 2'd2;

    typedef struct packed {
        logic opens;   // head or single: starts a packet
        logic closes;  // tail or single: ends a packet
    } flit_kind_t;

    // The encoding puts "opens" in bit 1 and "closes" in bit 0.
    function automatic flit_kind_t flit_kind(input logic [1:0] ftype);
        flit_kind_t k;
        k.opens  = ftype[1];
        k.closes = ftype[0];
        return k;
    endfunction

endpackage

// File: rtl/route_calc.sv
// route_calc -- combinational dimension-order route computation.
//   Default build: XY order (X resolved first).
//   IRC_YX_ROUTE_EN defined: YX order (Y resolved first).
// Ports:
//   x_cur, y_cur  in   ADDR_WIDTH  this router's coordinates
//   x_des, y_des  in   ADDR_WIDTH  destination coordinates (unsigned)
//   port          out  3           port code from noc_pkg
module route_calc
    import noc_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic [ADDR_WIDTH-1:0] x_cur,
    input  logic [ADDR_WIDTH-1:0] y_cur,
    input  logic [ADDR_WIDTH-1:0] x_des,
    input  logic [ADDR_WIDTH-1:0] y_des,
    output logic [2:0]            port
);

    always_comb begin
        port = PORT_LOCAL;
`ifdef IRC_YX_ROUTE_EN
        if (y_des > y_cur)      port = PORT_N;
        else if (y_des < y_cur) port = PORT_S;
        else if (x_des > x_cur) port = PORT_E;
        else if (x_des < x_cur) port = PORT_W;
`else
        if (x_des > x_cur)      port = PORT_E;
        else if (x_des < x_cur) port = PORT_W;
        else if (y_des > y_cur) port = PORT_N;
        else if (y_des < y_cur) port = PORT_S;
`endif
    end

endmodule

// File: rtl/input_route_ctrl.sv
// input_route_ctrl -- NoC router input-port controller.
//   Reads a show-ahead input FIFO, computes the route of each head flit,
//   requests/locks an output port (wormhole) and forwards flits downstream.
//   Stray body/tail flits seen while idle are popped and reported.
//   Optional: define IRC_YX_ROUTE_EN for YX instead of XY routing.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   x_cur, y_cur          router coordinates (latched during reset)
//   data_in, empty, read  FIFO head flit, empty flag, pop strobe
//   req_port, req_valid   output-port request / lock to the arbiter
//   grant                 arbiter grant
//   out_ready             downstream accepts a flit
//   data_out, data_valid  forwarded flit and qualifier
//   err_drop              one-cycle pulse per dropped stray flit
// DATA_WIDTH must be at least 2*ADDR_WIDTH+2, N_REGISTER at least 3.
module input_route_ctrl
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int N_REGISTER = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] x_cur,
    input  logic [ADDR_WIDTH-1:0] y_cur,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  empty,
    output logic                  read,
    output logic [N_REGISTER-1:0] req_port,
    output logic                  req_valid,
    input  logic                  grant,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  err_drop
);

    localparam logic [N_REGISTER-1:0] NONE_CODE = {N_REGISTER{1'b1}};

    irc_state_t            state;
    logic [ADDR_WIDTH-1:0] x_cur_q, y_cur_q;
    logic [2:0]            route_port;
    flit_kind_t            kind;

    assign kind = flit_kind(data_in[DATA_WIDTH-1:DATA_WIDTH-2]);

    route_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_route (
        .x_cur (x_cur_q),
        .y_cur (y_cur_q),
        .x_des (data_in[ADDR_WIDTH-1:0]),
        .y_des (data_in[2*ADDR_WIDTH-1:ADDR_WIDTH]),
        .port  (route_port)
    );

    // Pop strobe. In IDLE only stray flits are popped; a head stays at the
    // FIFO head until the output is granted so XFER forwards it first.
    always_comb begin
        read = 1'b0;
        if (rst && !empty) begin
            case (state)
                ST_IDLE: read = !kind.opens;
                ST_XFER: read = out_ready;
                default: read = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            req_port   <= NONE_CODE;
            req_valid  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            err_drop   <= 1'b0;
            x_cur_q    <= x_cur;
            y_cur_q    <= y_cur;
        end else begin
            err_drop   <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        if (kind.opens) begin
                            req_port  <= N_REGISTER'(route_port);
                            req_valid <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            err_drop <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (grant) state <= ST_XFER;
                end
                ST_XFER: begin
                    // Grant is not looked at here: the lock holds the output
                    // until the closing flit. A mid-packet head has no close
                    // bit, so it passes through as an ordinary body flit.
                    if (read) begin
                        data_out   <= data_in;
                        data_valid <= 1'b1;
                        if (kind.closes) begin
                            req_valid <= 1'b0;
                            req_port  <= NONE_CODE;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_valid <= 1'b0;
                    req_port  <= NONE_CODE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_route_ctrl.sv
// tb_input_route_ctrl -- directed self-checking bench for input_route_ctrl.
// A small show-ahead FIFO model feeds the DUT; inputs change 1 time unit
// after a rising edge and outputs are checked 1 time unit later.
module tb_input_route_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  x_cur, y_cur;
    logic [15:0] data_in;
    logic        empty;
    logic        read;
    logic [2:0]  req_port;
    logic        req_valid;
    logic        grant;
    logic        out_ready;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err_drop;

    int vectors     = 0;
    int miscompares = 0;

    // Destination (3,0) from router (1,1)
`ifdef IRC_YX_ROUTE_EN
    localparam logic [2:0] EXP_P30 = 3'b100;
`else
    localparam logic [2:0] EXP_P30 = 3'b001;
`endif

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [15:0] mem [0:31];
    logic [4:0]  wr_ptr = '0;
    logic [4:0]  rd_ptr = '0;
    assign empty   = (wr_ptr == rd_ptr);
    assign data_in = mem[rd_ptr];
    always @(posedge clk) if (read) rd_ptr <= rd_ptr + 5'd1;

    input_route_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .x_cur      (x_cur),
        .y_cur      (y_cur),
        .data_in    (data_in),
        .empty      (empty),
        .read       (read),
        .req_port   (req_port),
        .req_valid  (req_valid),
        .grant      (grant),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .err_drop   (err_drop)
    );

    task automatic push(input logic [15:0] f);
        mem[wr_ptr] = f;
        wr_ptr      = wr_ptr + 5'd1;
    endtask

    // Advance to the next drive point (1 unit after the rising edge)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before checking
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst = 1'b0; x_cur = 2'd1; y_cur = 2'd1; grant = 1'b0; out_ready = 1'b0;

        // Reset with a stray body flit waiting: read must stay low
        #1;
        push(16'h0010);
        settle();
        chk("rst_read_low", read, 1'b0);
        step();
        step();
        chk("rst_req_port", req_port, 3'b111);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_data_out", data_out, 16'h0);
        chk("rst_err_drop", err_drop, 1'b0);
        chk("rst_read", read, 1'b0);

        // Stray body flit in IDLE is dropped
        rst = 1'b1;
        settle();
        chk("stray_read", read, 1'b1);
        step();
        chk("stray_err_drop", err_drop, 1'b1);
        chk("stray_req_valid", req_valid, 1'b0);
        chk("stray_read_empty", read, 1'b0);
        step();
        chk("stray_err_clear", err_drop, 1'b0);

        // Packet head (3,0), body, tail; grant after 2 cycles of request
        push(16'h8003); push(16'h0011); push(16'h4022);
        settle();
        chk("pkt_idle_no_read", read, 1'b0);
        step();
        chk("pkt_req_valid", req_valid, 1'b1);
        chk("pkt_req_port", req_port, EXP_P30);
        chk("pkt_req_no_read", read, 1'b0);
        step();
        chk("pkt_req_hold", req_valid, 1'b1);
        grant = 1'b1;
        settle();
        chk("pkt_req_grant_no_read", read, 1'b0);
        step();
        grant = 1'b0; out_ready = 1'b1;   // grant loss must not stall
        settle();
        chk("pkt_xfer_read_head", read, 1'b1);
        chk("pkt_xfer_dv0", data_valid, 1'b0);
        step();
        chk("pkt_dv_head", data_valid, 1'b1);
        chk("pkt_data_head", data_out, 16'h8003);
        chk("pkt_read_body", read, 1'b1);
        step();
        chk("pkt_data_body", data_out, 16'h0011);
        chk("pkt_read_tail", read, 1'b1);
        chk("pkt_lock_held", req_valid, 1'b1);
        step();
        chk("pkt_data_tail", data_out, 16'h4022);
        chk("pkt_dv_tail", data_valid, 1'b1);
        chk("pkt_unlock", req_valid, 1'b0);
        chk("pkt_port_none", req_port, 3'b111);
        chk("pkt_no_read", read, 1'b0);
        step();
        chk("pkt_dv_drop", data_valid, 1'b0);

        // Dest (0,1) -> W; grant high in IDLE; stall; mid-packet head
        push(16'h8004); push(16'h0015); push(16'h8033); push(16'h4026);
        grant = 1'b1;
        settle();
        chk("w_idle_no_read", read, 1'b0);
        step();
        chk("w_req_valid", req_valid, 1'b1);
        chk("w_req_port", req_port, 3'b010);
        chk("w_req_no_read", read, 1'b0);
        step();
        chk("w_xfer_read", read, 1'b1);
        step();
        out_ready = 1'b0;
        settle();
        chk("w_data_head", data_out, 16'h8004);
        chk("w_stall_read0", read, 1'b0);
        step();
        chk("w_stall_dv1", data_valid, 1'b0);
        chk("w_stall_read1", read, 1'b0);
        step();
        chk("w_stall_dv2", data_valid, 1'b0);
        chk("w_stall_read2", read, 1'b0);
        chk("w_stall_lock", req_valid, 1'b1);
        step();
        out_ready = 1'b1;
        settle();
        chk("w_stall_dv3", data_valid, 1'b0);
        chk("w_resume_read", read, 1'b1);
        step();
        chk("w_data_body", data_out, 16'h0015);
        chk("w_read_midhead", read, 1'b1);
        step();
        chk("w_data_midhead", data_out, 16'h8033);
        chk("w_midhead_lock", req_valid, 1'b1);
        chk("w_midhead_port", req_port, 3'b010);
        step();
        chk("w_data_tail", data_out, 16'h4026);
        chk("w_unlock", req_valid, 1'b0);
        grant = 1'b0;

        // Single flit to (1,1) -> local
        push(16'hC005);
        settle();
        chk("s_idle_no_read", read, 1'b0);
        step();
        chk("s_req_port", req_port, 3'b000);
        chk("s_req_valid", req_valid, 1'b1);
        grant = 1'b1;
        step();
        grant = 1'b0;
        settle();
        chk("s_read", read, 1'b1);
        step();
        chk("s_unlock", req_valid, 1'b0);
        chk("s_port_none", req_port, 3'b111);
        chk("s_data", data_out, 16'hC005);
        chk("s_dv", data_valid, 1'b1);
        chk("s_no_read", read, 1'b0);

        // Reset mid-packet: remaining body and tail dropped
        push(16'h8003); push(16'h0017); push(16'h4028);
        grant = 1'b1;
        step();
        chk("r_req_port", req_port, EXP_P30);
        step();
        chk("r_read_head", read, 1'b1);
        step();
        rst = 1'b0;
        settle();
        chk("r_read_in_rst", read, 1'b0);
        step();
        rst = 1'b1; grant = 1'b0;
        settle();
        chk("r_req_valid", req_valid, 1'b0);
        chk("r_port_none", req_port, 3'b111);
        chk("r_dv", data_valid, 1'b0);
        chk("r_data_out", data_out, 16'h0);
        chk("r_drop_body_read", read, 1'b1);
        step();
        chk("r_err_body", err_drop, 1'b1);
        chk("r_drop_tail_read", read, 1'b1);
        step();
        chk("r_err_tail", err_drop, 1'b1);
        chk("r_empty_no_read", read, 1'b0);
        chk("r_no_lock", req_valid, 1'b0);
        step();
        chk("r_err_clear", err_drop, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
